vec_mask_packer: RTL and testbench

- Consumer side of the vector compare unit.
- Accepts compare results one register-group beat at a time. Each beat is VLEN bits holding one result bit in the LSB of every SEW-wide element lane.
- Packs them into a dense RVV mask: bit i = element i.
- Applies vl-based tail policy and hands the finished mask to the mask-register writeback port over a valid/ready handshake.

---
 rtl/vec_pkg.sv | 37 +++
 rtl/vec_mask_extract.sv | 41 ++++
 rtl/vec_mask_packer.sv | 169 ++++++++++++++++
 tb/tb_vec_mask_packer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector mask packing path: default sizes,
// SEW encodings, packer FSM states and the dense mask type.
package vec_pkg;

   localparam int VLEN_DEF     = 512;
   localparam int ELEN_DEF     = 32;
   localparam int MAX_LMUL_DEF = 8;

   localparam logic [6:0] SEW_8  = 7'd8;
   localparam logic [6:0] SEW_16 = 7'd16;
   localparam logic [6:0] SEW_32 = 7'd32;

   typedef enum logic [1:0] {
      PK_IDLE  = 2'd0,
      PK_ACCUM = 2'd1,
      PK_DONE  = 2'd2
   } pkState_e;

   typedef logic [VLEN_DEF-1:0] mask_t;

   // Elements per register for a legal SEW no wider than ELEN; zero marks an illegal SEW.
   function automatic int sewElems(input logic [6:0] sewVal, input int vlen, input int elen);
      int n;
      n = 0;
      case (sewVal)
         SEW_8:   n = vlen / 8;
         SEW_16:  n = vlen / 16;
         SEW_32:  n = vlen / 32;
         default: n = 0;
      endcase
      if (int'(sewVal) > elen) begin
         n = 0;
      end
      return n;
   endfunction

endpackage

// File: rtl/vec_mask_extract.sv
// Pulls the LSB of every SEW-wide lane out of a compare beat and packs the
// results densely (element j at bit j). Unused upper bits are zero.
import vec_pkg::*;

module vec_mask_extract #(
   parameter int VLEN = VLEN_DEF
) (
   input  logic [VLEN-1:0]   cmp_i,
   input  logic [6:0]        sew_i,
   output logic [VLEN/8-1:0] beat_o
);

   logic unusedCmpBits;

   // Only lane LSBs carry results; the remaining bits are deliberately ignored.
   assign unusedCmpBits = ^cmp_i;

   // Gather one result bit per lane according to the element width.
   always_comb begin
      beat_o = '0;
      case (sew_i)
         SEW_8: begin
            for (int j = 0; j < VLEN / 8; j++) begin
               beat_o[j] = cmp_i[j*8];
            end
         end
         SEW_16: begin
            for (int j = 0; j < VLEN / 16; j++) begin
               beat_o[j] = cmp_i[j*16];
            end
         end
         SEW_32: begin
            for (int j = 0; j < VLEN / 32; j++) begin
               beat_o[j] = cmp_i[j*32];
            end
         end
         default: beat_o = '0;
      endcase
   end

endmodule

// File: rtl/vec_mask_packer.sv
// Collects compare beats for one register group, packs them into a dense
// RVV mask, applies the vl tail policy and offers the result to writeback.
import vec_pkg::*;

module vec_mask_packer #(
   parameter int VLEN     = VLEN_DEF,
   parameter int ELEN     = ELEN_DEF,
   parameter int MAX_LMUL = MAX_LMUL_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [VLEN-1:0]       cmp_result,
   input  logic [6:0]            sew,
   input  logic                  beat_last,
   input  logic [$clog2(VLEN):0] vl,
   input  logic                  vta,
   input  logic [VLEN-1:0]       old_mask,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [VLEN-1:0]       mask_out,
   output logic                  err
);

   localparam int VLW = $clog2(VLEN) + 1;
   localparam int EW  = VLEN / 8;
   localparam int CW  = $clog2(MAX_LMUL + 1);
   localparam logic [CW-1:0]  CNT_SAT = CW'(MAX_LMUL);
   localparam logic [VLW-1:0] VL_MAX  = VLW'(VLEN);

   pkState_e         state_q, state_d;
   logic [CW-1:0]    beatCnt_q, beatCnt_d;
   logic [VLEN-1:0]  accum_q, accum_d;
   logic [VLEN-1:0]  written_q, written_d;
   logic [6:0]       sew_q, sew_d;
   logic [VLW-1:0]   vl_q, vl_d;
   logic             vta_q, vta_d;
   logic [VLEN-1:0]  oldMask_q, oldMask_d;
   logic             err_q, err_d;

   logic             accept;
   logic             firstBeat;
   logic [6:0]       sewEff;
   logic [CW-1:0]    beatIdx;
   logic             beatInRange;
   logic [VLW-1:0]   vlClamped;
   logic [EW-1:0]    beatVec;
   logic [EW-1:0]    laneBits;
   logic [VLEN-1:0]  placedBits;
   logic [VLEN-1:0]  placedMask;
   logic [VLEN-1:0]  merged;
   logic             sewOk;
   int               elems;
   int               shamt;

   // The first beat is steered by the live inputs; later beats use the values latched at beat 0.
   assign accept      = in_valid & in_ready;
   assign firstBeat   = (state_q == PK_IDLE);
   assign sewEff      = firstBeat ? sew : sew_q;
   assign beatIdx     = firstBeat ? '0 : beatCnt_q;
   assign beatInRange = (beatIdx < CNT_SAT);
   assign vlClamped   = (vl > VL_MAX) ? VL_MAX : vl;

   assign in_ready  = rst_n && (state_q != PK_DONE);
   assign out_valid = (state_q == PK_DONE);
   assign mask_out  = (state_q == PK_DONE) ? merged : '0;
   assign err       = err_q;

   vec_mask_extract #(
      .VLEN (VLEN)
   ) uExtract (
      .cmp_i  (cmp_result),
      .sew_i  (sewEff),
      .beat_o (beatVec)
   );

   // Position the current beat's packed bits and its written-lane mask at element k*E.
   always_comb begin
      elems      = sewElems(sewEff, VLEN, ELEN);
      sewOk      = (elems != 0);
      shamt      = int'(beatIdx) * elems;
      laneBits   = (elems == 0) ? '0 : ({EW{1'b1}} >> (EW - elems));
      placedMask = {{(VLEN-EW){1'b0}}, laneBits} << shamt;
      placedBits = {{(VLEN-EW){1'b0}}, beatVec & laneBits} << shamt;
   end

   // Next-state logic: group start, accumulation with overflow discard, and output hold.
   always_comb begin
      state_d   = state_q;
      beatCnt_d = beatCnt_q;
      accum_d   = accum_q;
      written_d = written_q;
      sew_d     = sew_q;
      vl_d      = vl_q;
      vta_d     = vta_q;
      oldMask_d = oldMask_q;
      err_d     = err_q;
      case (state_q)
         PK_IDLE: begin
            if (accept) begin
               sew_d     = sew;
               vl_d      = vlClamped;
               vta_d     = vta;
               oldMask_d = old_mask;
               accum_d   = placedBits;
               written_d = placedMask;
               beatCnt_d = CW'(1);
               err_d     = !sewOk;
               state_d   = beat_last ? PK_DONE : PK_ACCUM;
            end
         end
         PK_ACCUM: begin
            if (accept) begin
               if (beatInRange) begin
                  accum_d   = accum_q | placedBits;
                  written_d = written_q | placedMask;
               end else begin
                  err_d = 1'b1;
               end
               beatCnt_d = (beatCnt_q == CNT_SAT) ? beatCnt_q : beatCnt_q + CW'(1);
               if (beat_last) begin
                  state_d = PK_DONE;
               end
            end
         end
         PK_DONE: begin
            if (out_ready) begin
               state_d = PK_IDLE;
            end
         end
         default: state_d = PK_IDLE;
      endcase
   end

   // Tail merge: written active elements keep their compare bit, everything else takes the tail fill.
   always_comb begin
      merged = '0;
      for (int i = 0; i < VLEN; i++) begin
         merged[i] = ((i < int'(vl_q)) && written_q[i]) ? accum_q[i] : (vta_q | oldMask_q[i]);
      end
   end

   // State registers with synchronous active-low reset discarding any partial group.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= PK_IDLE;
         beatCnt_q <= '0;
         accum_q   <= '0;
         written_q <= '0;
         sew_q     <= '0;
         vl_q      <= '0;
         vta_q     <= 1'b0;
         oldMask_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         beatCnt_q <= beatCnt_d;
         accum_q   <= accum_d;
         written_q <= written_d;
         sew_q     <= sew_d;
         vl_q      <= vl_d;
         vta_q     <= vta_d;
         oldMask_q <= oldMask_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_vec_mask_packer.sv
// Scoreboard bench for vec_mask_packer: each group's expected mask/err is
// queued when its beats are driven and compared when writeback takes it.
module tb_vec_mask_packer;
   import vec_pkg::*;

   localparam int VLEN = VLEN_DEF;
   localparam int VLW  = $clog2(VLEN) + 1;

   typedef struct {
      logic [VLEN-1:0] mask;
      logic            err;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [VLEN-1:0] cmp_result;
   logic [6:0]      sew;
   logic            beat_last;
   logic [VLW-1:0]  vl;
   logic            vta;
   logic [VLEN-1:0] old_mask;
   logic            out_valid;
   logic            out_ready;
   logic [VLEN-1:0] mask_out;
   logic            err;

   exp_t            expQ[$];
   int              nVectors = 0;
   int              nMiscompares = 0;
   logic [VLEN-1:0] beatBuf [16];

   vec_mask_packer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .cmp_result (cmp_result),
      .sew        (sew),
      .beat_last  (beat_last),
      .vl         (vl),
      .vta        (vta),
      .old_mask   (old_mask),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .mask_out   (mask_out),
      .err        (err)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
      nVectors++;
      if (got !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [VLEN-1:0] randVec();
      logic [VLEN-1:0] v;
      for (int k = 0; k < VLEN / 32; k++) begin
         v[k*32 +: 32] = $urandom;
      end
      return v;
   endfunction

   // Element-level reference: element e belongs to beat e/E, lane e%E.
   function automatic logic [VLEN-1:0] modelMask(input int sewv, input int vlv, input bit vtav,
                                                 input logic [VLEN-1:0] oldv, input int nb);
      logic [VLEN-1:0] m;
      logic [VLEN-1:0] b;
      bit legal;
      int elemsPer, used, vle;
      legal    = (sewv == 8) || (sewv == 16) || (sewv == 32);
      vle      = (vlv > VLEN) ? VLEN : vlv;
      elemsPer = legal ? VLEN / sewv : 1;
      used     = (nb > 8) ? 8 : nb;
      m        = '0;
      for (int e = 0; e < VLEN; e++) begin
         if (legal && (e < vle) && (e < used * elemsPer)) begin
            b    = beatBuf[e / elemsPer];
            m[e] = b[(e % elemsPer) * sewv];
         end else begin
            m[e] = vtav ? 1'b1 : oldv[e];
         end
      end
      return m;
   endfunction

   // Drive one beat and hold it until the DUT accepts it (bounded wait).
   task automatic applyStimulus(input logic [VLEN-1:0] cmp, input int sewv, input int vlv,
                                input bit vtav, input logic [VLEN-1:0] oldv, input bit last);
      bit accepted;
      in_valid   = 1'b1;
      cmp_result = cmp;
      sew        = 7'(sewv);
      vl         = VLW'(vlv);
      vta        = vtav;
      old_mask   = oldv;
      beat_last  = last;
      accepted   = 1'b0;
      for (int c = 0; c < 20 && !accepted; c++) begin
         @(negedge clk);
         if (in_ready) accepted = 1'b1;
      end
      @(posedge clk);
      #2;
      in_valid  = 1'b0;
      beat_last = 1'b0;
      if (!accepted) checkOutput("beat_timeout", VLEN'(0), VLEN'(1));
   endtask

   // Send a whole group; non-first beats carry junk side-band values that must be ignored.
   task automatic runGroup(input int sewv, input int vlv, input bit vtav,
                           input logic [VLEN-1:0] oldv, input int nb);
      exp_t e;
      bit legal;
      legal  = (sewv == 8) || (sewv == 16) || (sewv == 32);
      e.mask = modelMask(sewv, vlv, vtav, oldv, nb);
      e.err  = !legal || (nb > 8);
      expQ.push_back(e);
      for (int b = 0; b < nb; b++) begin
         if (b == 0) begin
            applyStimulus(beatBuf[0], sewv, vlv, vtav, oldv, nb == 1);
         end else begin
            applyStimulus(beatBuf[b], 99, int'($urandom_range(0, 1023)),
                          bit'($urandom_range(0, 1)), randVec(), b == nb - 1);
         end
      end
      checkOutput("latency", VLEN'(out_valid), VLEN'(1));
   endtask

   task automatic drain();
      for (int c = 0; c < 50 && expQ.size() > 0; c++) begin
         @(posedge clk);
      end
      #2;
      if (expQ.size() > 0) begin
         checkOutput("drain_timeout", VLEN'(expQ.size()), VLEN'(0));
         expQ.delete();
      end
   endtask

   // Scoreboard consumer: compare whenever writeback takes a mask.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_output", VLEN'(1), VLEN'(0));
            end else begin
               e = expQ.pop_front();
               checkOutput("mask", mask_out, e.mask);
               checkOutput("err", VLEN'(err), VLEN'(e.err));
            end
         end
      end
   end

   // Time bound for the whole run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: run did not complete");
      nMiscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

   // Directed scenarios followed by a short random sweep.
   initial begin
      logic [VLEN-1:0] oldv;
      logic [VLEN-1:0] expM;
      int sewv;
      in_valid   = 1'b0;
      cmp_result = '0;
      sew        = 7'd8;
      beat_last  = 1'b0;
      vl         = '0;
      vta        = 1'b0;
      old_mask   = '0;
      out_ready  = 1'b1;
      rst_n      = 1'b0;

      repeat (2) @(posedge clk);
      #2;
      checkOutput("rst_out_valid", VLEN'(out_valid), VLEN'(0));
      checkOutput("rst_mask", mask_out, '0);
      checkOutput("rst_err", VLEN'(err), VLEN'(0));
      checkOutput("rst_in_ready", VLEN'(in_ready), VLEN'(0));
      rst_n = 1'b1;
      #1;
      checkOutput("idle_in_ready", VLEN'(in_ready), VLEN'(1));

      // SEW=8, vl=3, tail agnostic; a non-lane bit is set and must be ignored
      beatBuf[0]     = '0;
      beatBuf[0][0]  = 1'b1;
      beatBuf[0][16] = 1'b1;
      beatBuf[0][3]  = 1'b1;
      runGroup(8, 3, 1'b1, '0, 1);
      checkOutput("t1_mask", mask_out, {{(VLEN-3){1'b1}}, 3'b101});
      checkOutput("t1_err", VLEN'(err), VLEN'(0));
      drain();

      // SEW=32, vl=20, undisturbed with zero old mask
      beatBuf[0] = '0;
      beatBuf[1] = '0;
      for (int l = 0; l < 16; l++) beatBuf[0][l*32] = 1'b1;
      for (int l = 0; l < 4; l++) beatBuf[1][l*32] = 1'b1;
      runGroup(32, 20, 1'b0, '0, 2);
      checkOutput("t2_mask", mask_out, {{(VLEN-20){1'b0}}, 20'hFFFFF});
      drain();

      // Backpressure: output held while a competing beat is offered
      out_ready  = 1'b0;
      beatBuf[0] = randVec();
      beatBuf[1] = randVec();
      oldv       = randVec();
      runGroup(16, 40, 1'b0, oldv, 2);
      expM       = expQ[0].mask;
      in_valid   = 1'b1;
      beat_last  = 1'b1;
      cmp_result = randVec();
      for (int c = 0; c < 5; c++) begin
         checkOutput("bp_mask", mask_out, expM);
         checkOutput("bp_valid", VLEN'(out_valid), VLEN'(1));
         checkOutput("bp_in_ready", VLEN'(in_ready), VLEN'(0));
         @(posedge clk);
         #2;
      end
      in_valid  = 1'b0;
      beat_last = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      checkOutput("bp_idle_valid", VLEN'(out_valid), VLEN'(0));
      checkOutput("bp_idle_ready", VLEN'(in_ready), VLEN'(1));
      drain();

      // Illegal SEW with tail agnostic: all ones, err set
      beatBuf[0] = randVec();
      beatBuf[1] = randVec();
      runGroup(12, 100, 1'b1, randVec(), 2);
      checkOutput("t4_mask", mask_out, {VLEN{1'b1}});
      checkOutput("t4_err", VLEN'(err), VLEN'(1));
      drain();

      // Nine beats at SEW=16: the ninth is discarded
      for (int b = 0; b < 9; b++) beatBuf[b] = randVec();
      runGroup(16, 512, 1'b0, randVec(), 9);
      checkOutput("t5_err", VLEN'(err), VLEN'(1));
      drain();

      // Reset in the middle of a group, then a clean group must show no stale bits
      applyStimulus({VLEN{1'b1}}, 8, 512, 1'b0, '0, 1'b0);
      applyStimulus({VLEN{1'b1}}, 8, 512, 1'b0, '0, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      checkOutput("midrst_valid", VLEN'(out_valid), VLEN'(0));
      checkOutput("midrst_in_ready", VLEN'(in_ready), VLEN'(0));
      rst_n = 1'b1;
      #1;
      checkOutput("midrst_idle", VLEN'(in_ready), VLEN'(1));
      beatBuf[0] = '0;
      runGroup(8, 128, 1'b0, '0, 1);
      checkOutput("t6_nostale", mask_out, '0);
      checkOutput("t6_err", VLEN'(err), VLEN'(0));
      drain();

      // Random legal groups
      for (int g = 0; g < 10; g++) begin
         case ($urandom_range(0, 2))
            0:       sewv = 8;
            1:       sewv = 16;
            default: sewv = 32;
         endcase
         for (int b = 0; b < 8; b++) beatBuf[b] = randVec();
         runGroup(sewv, int'($urandom_range(0, 600)), bit'($urandom_range(0, 1)),
                  randVec(), int'($urandom_range(1, 8)));
         drain();
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
